// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, FSM states, request payload and helpers.
package apb_pkg;

    localparam int unsigned ADDR_WIDTH  = 16;
    localparam int unsigned DATA_WIDTH  = 32;
    localparam int unsigned STRB_WIDTH  = DATA_WIDTH / 8;
    localparam int unsigned MAX_REQ     = 8;
    localparam int unsigned IDX_W       = $clog2(MAX_REQ);
    localparam int unsigned MAX_TIMEOUT = 255;
    localparam int unsigned TIMEOUT_W   = $clog2(MAX_TIMEOUT + 1);

    // Upper half of the address map is the privileged region
    localparam logic [ADDR_WIDTH-1:0] PRIV_BASE = ADDR_WIDTH'(16'h8000);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } apb_state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  write;
        logic [DATA_WIDTH-1:0] wdata;
        logic [STRB_WIDTH-1:0] strb;
        logic [2:0]            prot;
    } apb_req_t;

    // Word-aligned addresses only
    function automatic logic validAlign(input logic [ADDR_WIDTH-1:0] addr);
        return (addr & ALIGN_MASK) == '0;
    endfunction

    // Privileged, non-secure, instruction for the privileged region; plain data otherwise
    function automatic logic [2:0] getPprot(input logic [ADDR_WIDTH-1:0] addr);
        return (addr >= PRIV_BASE) ? 3'b111 : 3'b000;
    endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin grant: first valid requester after ptr, with wrap.
module apb_rr_arbiter
    import apb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt_c,
    output logic [IDX_W-1:0]   gnt_idx_c,
    output logic               gnt_any_c
);

    logic             hi_any;
    logic             lo_any;
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;

    // Lowest valid index above ptr wins; otherwise lowest valid index at or below ptr
    always_comb begin
        hi_any = 1'b0;
        lo_any = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_valid[j]) begin
                if (j > int'(ptr)) begin
                    hi_any = 1'b1;
                    hi_idx = IDX_W'(j);
                end else begin
                    lo_any = 1'b1;
                    lo_idx = IDX_W'(j);
                end
            end
        end
        gnt_any_c = hi_any | lo_any;
        gnt_idx_c = hi_any ? hi_idx : lo_idx;
        gnt_c     = gnt_any_c ? (NUM_REQ'(1) << gnt_idx_c) : '0;
    end

endmodule

// File: rtl/apb_arbiter_master.sv
// Round-robin arbitration of NUM_REQ requesters onto one APB4 completer port.
module apb_arbiter_master
    import apb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                          PCLK,
    input  logic                          PRESET,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_REQ*STRB_WIDTH-1:0] req_strb,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic                          PSEL,
    output logic                          PENABLE,
    output logic                          PWRITE,
    output logic [ADDR_WIDTH-1:0]         PADDR,
    output logic [DATA_WIDTH-1:0]         PWDATA,
    output logic [STRB_WIDTH-1:0]         PSTRB,
    output logic [2:0]                    PPROT,
    input  logic                          PREADY,
    input  logic                          PSLVERR,
    input  logic [DATA_WIDTH-1:0]         PRDATA
);

    // Last ACCESS wait count before abort; unused when TIMEOUT is 0
    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    apb_state_t           state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     gnt_q, gnt_d;
    apb_req_t             req_q, req_d;
    logic [TIMEOUT_W-1:0] wait_q, wait_d;
    logic                 psel_d, penable_d;
    logic [NUM_REQ-1:0]   rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_d;
    logic                 rsp_err_d;

    logic [NUM_REQ-1:0]    gnt_c;
    logic [IDX_W-1:0]      gnt_idx_c;
    logic                  gnt_any_c;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_write;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [STRB_WIDTH-1:0] sel_strb;

    apb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_valid (req_valid),
        .ptr       (ptr_q),
        .gnt_c     (gnt_c),
        .gnt_idx_c (gnt_idx_c),
        .gnt_any_c (gnt_any_c)
    );

    assign PADDR  = req_q.addr;
    assign PWRITE = req_q.write;
    assign PWDATA = req_q.wdata;
    assign PSTRB  = req_q.strb;
    assign PPROT  = req_q.prot;

    // Select the granted requester's payload
    always_comb begin
        sel_addr  = '0;
        sel_write = 1'b0;
        sel_wdata = '0;
        sel_strb  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_c[i]) begin
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_write = req_write[i];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_strb  = req_strb[i*STRB_WIDTH +: STRB_WIDTH];
            end
        end
    end

    // Next-state, latch and registered-output logic for the transfer sequencer
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        req_d       = req_q;
        wait_d      = wait_q;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        req_ready   = '0;
        unique case (state_q)
            IDLE: begin
                if (gnt_any_c) begin
                    req_ready   = gnt_c;
                    ptr_d       = gnt_idx_c;
                    gnt_d       = gnt_idx_c;
                    req_d.addr  = sel_addr;
                    req_d.write = sel_write;
                    req_d.wdata = sel_write ? sel_wdata : '0;
                    req_d.strb  = sel_write ? sel_strb : '0;
                    req_d.prot  = getPprot(sel_addr);
                    if (validAlign(sel_addr)) begin
                        state_d = SETUP;
                        psel_d  = 1'b1;
                    end else begin
                        state_d = ERROR;
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                psel_d    = 1'b1;
                penable_d = 1'b1;
                wait_d    = '0;
            end
            ACCESS: begin
                if (PREADY) begin
                    state_d     = IDLE;
                    rsp_valid_d = NUM_REQ'(1) << gnt_q;
                    rsp_rdata_d = req_q.write ? '0 : PRDATA;
                    rsp_err_d   = PSLVERR;
                end else if ((TIMEOUT != 0) && (wait_q == TO_LAST)) begin
                    state_d     = IDLE;
                    rsp_valid_d = NUM_REQ'(1) << gnt_q;
                    rsp_err_d   = 1'b1;
                end else begin
                    psel_d    = 1'b1;
                    penable_d = 1'b1;
                    wait_d    = wait_q + TIMEOUT_W'(1);
                end
            end
            ERROR: begin
                state_d     = IDLE;
                rsp_valid_d = NUM_REQ'(1) << gnt_q;
                rsp_err_d   = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops any in-flight transfer
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= IDLE;
            ptr_q     <= IDX_W'(NUM_REQ - 1);
            gnt_q     <= '0;
            req_q     <= '0;
            wait_q    <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            req_q     <= req_d;
            wait_q    <= wait_d;
            PSEL      <= psel_d;
            PENABLE   <= penable_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
        end
    end

endmodule

// File: doc/apb_arbiter_master.md
Name: apb_arbiter_master

Overview:
- Shares one APB4 completer port between NUM_REQ on-chip requesters with round-robin arbitration.
- Sequences each accepted request through the apb_pkg state machine (IDLE/SETUP/ACCESS/ERROR) and drives the APB master signals.
- Rejects misaligned addresses locally without touching the bus, and aborts transfers that stall too long.
- Sits between the requesters (CPU/DMA front-ends) and the APB peripheral bus.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT, 16, consecutive PREADY-low ACCESS cycles before abort. 0 disables the timeout.
- ADDR_WIDTH, DATA_WIDTH and STRB_WIDTH are taken from apb_pkg; they are not module parameters.

Ports:
- PCLK  in  1  clock; all logic is rising-edge.
- PRESET  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request.
- req_ready  out  NUM_REQ  one-hot; request accepted this cycle.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened; slice i belongs to requester i.
- req_write  in  NUM_REQ  1 = write.
- req_wdata  in  NUM_REQ*DATA_WIDTH  write data.
- req_strb  in  NUM_REQ*STRB_WIDTH  byte strobes.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse.
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid.
- rsp_err  out  1  error flag, valid with rsp_valid.
- PSEL, PENABLE, PWRITE  out  1 each  APB control.
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  DATA_WIDTH  APB write data.
- PSTRB  out  STRB_WIDTH  APB write strobes.
- PPROT  out  3  APB protection.
- PREADY, PSLVERR  in  1 each  APB completer response.
- PRDATA  in  DATA_WIDTH  APB read data.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE; all outputs 0; rr pointer=NUM_REQ-1, so requester 0 wins first.
  - Any in-flight transfer is dropped; no rsp_valid is generated for it.
- IDLE:
  - If any req_valid, grant g = first set bit searching from (ptr+1) mod NUM_REQ upward with wrap.
  - req_ready[g]=1 combinationally in this cycle; this is the only cycle req_ready is high.
  - At the edge, latch g, addr, write, wdata, strb; set ptr=g.
  - Latched PPROT = getPprot(addr).
  - Latched PWDATA and PSTRB are forced to 0 for reads.
  - Next state: ERROR if validAlign(addr) is FALSE, else SETUP.
  - With no requests, stay in IDLE with PSEL=0.
- SETUP: PSEL=1, PENABLE=0, address/control/data driven from the latches. Next state is ACCESS unconditionally.
- ACCESS:
  - PSEL=1, PENABLE=1; all bus outputs held stable.
  - wait_cnt is cleared on entry and increments each cycle with PREADY=0.
  - PREADY=1 takes precedence: capture PRDATA (reads) or 0 (writes) and PSLVERR, then go to IDLE.
  - Timeout: if PREADY=0 and wait_cnt==TIMEOUT-1 (TIMEOUT>0), abort. Set rsp_err=1, rsp_rdata=0, go to IDLE.
- ERROR: PSEL=0 for one cycle; set rsp_err=1, rsp_rdata=0; go to IDLE.
- Response timing:
  - rsp_valid[g], rsp_rdata and rsp_err are registered and asserted for exactly one cycle: the first IDLE cycle after ACCESS/ERROR exit.
  - Outside that cycle all three are 0.
- Latency:
  - Zero wait states: accept at edge 0, SETUP in cycle 1, ACCESS in cycle 2, rsp_valid in cycle 3.
  - Back-to-back transfers always have at least one IDLE cycle (PSEL=0) between them.
  - A new grant may coincide with the rsp_valid cycle.
- Simultaneous events:
  - All requesters valid: strict rotation 0,1,...,NUM_REQ-1,0,...
  - A requester that drops req_valid before being granted is skipped.
- Misaligned requests never assert PSEL and consume 3 cycles (accept, ERROR, response).
- PADDR is not changed for addresses in the privileged region; PPROT alone reflects the region.

Decomposition:
- apb_pkg supplies the state enum, ADDR_WIDTH, DATA_WIDTH, STRB_WIDTH, validAlign and getPprot.
- Add to apb_pkg: MAX_REQ=8 and a TIMEOUT_W constant (clog2 of the maximum TIMEOUT) for the wait counter.
- One sub-module, apb_rr_arbiter:
  - Purely combinational grant from req_valid and ptr.
  - Instantiated once; ptr update stays in the top module.

Test Plan:
- Single write, req 0, addr 16'h0010, wdata 32'hDEADBEEF, strb 4'hF, PREADY=1 → SETUP then ACCESS with PSEL/PENABLE/PADDR correct; PPROT=3'b000; rsp_valid[0] in cycle 3; rsp_err=0.
- Read, req 1, addr 16'h8004, PREADY low 2 cycles, PRDATA=32'h12345678 → PPROT=3'b111; PSTRB=0; PENABLE held 3 cycles; rsp_rdata=32'h12345678 on rsp_valid[1].
- Both requesters hold req_valid for 4 transfers → grant order 0,1,0,1; at least one IDLE cycle between transfers.
- Misaligned, req 0, addr 16'h0006 → PSEL never asserted; rsp_valid[0] with rsp_err=1 two cycles after accept.
- TIMEOUT=4, PREADY stuck 0 → exactly 4 ACCESS cycles, then PSEL=0, rsp_err=1, rsp_rdata=0. Also: PSLVERR=1 with PREADY=1 → rsp_err=1.
- PRESET asserted mid-ACCESS → PSEL/PENABLE low immediately; no rsp_valid; after release the first grant goes to requester 0.
